// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router input port: buffers a host payload, then sends header, payload and parity.
// Latency: bus traffic starts the cycle after the last payload byte is taken; tx_done comes ERR_WAIT cycles after parity acceptance.
// Backpressure: host side is valid/ready (ready only in FILL); router side stalls on busy, and pkt_valid/data_in hold while busy=1.
//
// Ports:
//   clock, resetn            rising-edge clock, asynchronous active-low reset
//   tx_start/tx_addr/tx_len  transfer request, sampled only while idle
//   tx_data/_valid/_ready    host payload stream
//   busy, err                router back-pressure and parity-error response
//   pkt_valid, data_in       byte stream into the router
//   tx_active/done/err/reject  status toward the host
module router_pkt_tx #(
  parameter int MAX_LEN  = 63,
  parameter int ERR_WAIT = 3
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       tx_start,
  input  logic [1:0] tx_addr,
  input  logic [5:0] tx_len,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  output logic       tx_data_ready,
  input  logic       busy,
  input  logic       err,
  output logic       pkt_valid,
  output logic [7:0] data_in,
  output logic       tx_active,
  output logic       tx_done,
  output logic       tx_err,
  output logic       tx_reject
);

  localparam int CW = $clog2(ERR_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_HDR,
    S_PAY,
    S_PAR,
    S_CHK
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [1:0]     addr_q;
  logic [5:0]     len_q;
  logic [5:0]     idx;
  logic [7:0]     parity;
  logic [CW-1:0]  wait_cnt;
  logic [7:0]     pay_mem [0:MAX_LEN-1];

  logic           req_legal;
  logic           idx_last;
  logic [7:0]     header;

  assign req_legal = (tx_addr != 2'd3) && (tx_len != 6'd0);
  // idx never passes len-1, so a length-63 packet uses the whole buffer without wrapping.
  assign idx_last  = (idx == len_q - 6'd1);
  assign header    = {len_q, addr_q};
  assign tx_active = (state != S_IDLE);

  // Next state and bus outputs are decoded from state and registers only;
  // busy steers transitions but never reaches an output combinationally.
  always_comb begin
    state_nxt     = state;
    pkt_valid     = 1'b0;
    data_in       = 8'h00;
    tx_data_ready = 1'b0;
    case (state)
      S_IDLE: begin
        if (tx_start && req_legal) state_nxt = S_FILL;
      end
      S_FILL: begin
        tx_data_ready = 1'b1;
        if (tx_data_valid && idx_last) state_nxt = S_HDR;
      end
      S_HDR: begin
        pkt_valid = 1'b1;
        data_in   = header;
        if (!busy) state_nxt = S_PAY;
      end
      S_PAY: begin
        pkt_valid = 1'b1;
        data_in   = pay_mem[idx];
        if (!busy && idx_last) state_nxt = S_PAR;
      end
      S_PAR: begin
        // pkt_valid is already low while the parity byte is presented.
        data_in = parity;
        if (!busy) state_nxt = S_CHK;
      end
      S_CHK: begin
        if (wait_cnt == CW'(1)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q    <= 2'd0;
      len_q     <= 6'd0;
      idx       <= 6'd0;
      parity    <= 8'h00;
      wait_cnt  <= '0;
      tx_err    <= 1'b0;
      tx_done   <= 1'b0;
      tx_reject <= 1'b0;
    end else begin
      tx_done   <= 1'b0;
      tx_reject <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_start) begin
            if (req_legal) begin
              addr_q <= tx_addr;
              len_q  <= tx_len;
              parity <= {tx_len, tx_addr};
              idx    <= 6'd0;
              tx_err <= 1'b0;
            end else begin
              tx_reject <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (tx_data_valid) begin
            parity <= parity ^ tx_data;
            idx    <= idx_last ? 6'd0 : idx + 6'd1;
          end
        end
        S_PAY: begin
          if (!busy) idx <= idx_last ? 6'd0 : idx + 6'd1;
        end
        S_PAR: begin
          if (!busy) wait_cnt <= CW'(ERR_WAIT);
        end
        S_CHK: begin
          // err is watched on each of the ERR_WAIT edges after parity acceptance;
          // the final one also raises tx_done, which shows while already idle.
          if (err) tx_err <= 1'b1;
          wait_cnt <= wait_cnt - CW'(1);
          if (wait_cnt == CW'(1)) tx_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Payload store carries no reset: it is always fully rewritten before it is read.
  always_ff @(posedge clock) begin
    if (state == S_FILL && tx_data_valid) pay_mem[idx] <= tx_data;
  end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
- Packet transmitter that drives the router's input port (pkt_valid, data_in); the router FSM is the receiver at the other end.
- Accepts a transfer request (address, length) plus payload bytes from a host-side valid/ready stream and buffers the whole payload internally.
- Then emits header, payload and parity bytes under the router's busy back-pressure, and reports the router's parity-error response.
- Sits in the testbench/source side of the 1x3 router subsystem and serves as the reusable packet source for integration.

Parameters:
- MAX_LEN, 63: maximum payload bytes. Fixed by the 6-bit length field; sizes the buffer.
- ERR_WAIT, 3: cycles after parity acceptance during which err is sampled.

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- tx_start  in  1  request pulse; sampled only in IDLE.
- tx_addr  in  2  destination port 0..2; 3 is illegal.
- tx_len  in  6  payload length 1..63; 0 is illegal.
- tx_data  in  8  payload byte.
- tx_data_valid  in  1  payload byte valid.
- tx_data_ready  out  1  high in FILL only.
- busy  in  1  router back-pressure.
- err  in  1  router parity-error flag.
- pkt_valid  out  1  to router.
- data_in  out  8  to router.
- tx_active  out  1  high in every state except IDLE.
- tx_done  out  1  one-cycle pulse at packet end.
- tx_err  out  1  err was observed for the last packet; holds until next accepted tx_start.
- tx_reject  out  1  one-cycle pulse on an illegal request.

Behaviour:
- Reset (async, resetn=0): state=IDLE; pkt_valid=0, data_in=0, tx_data_ready=0, tx_active=0, tx_done=0, tx_err=0, tx_reject=0; counters and parity cleared. Buffer contents are don't-care.
- Reset asserted mid-packet aborts immediately: pkt_valid drops asynchronously, and the next request starts from IDLE.
- All outputs are registered or decoded from state/registers. There is no combinational path from busy to outputs.
- Header = {tx_len, tx_addr}. Parity = XOR of the header and all payload bytes, computed incrementally during FILL.
- Byte acceptance rule: the byte on data_in is accepted at a rising edge where busy==0. While busy==1, pkt_valid and data_in hold stable.
- States:
  - IDLE: on tx_start with tx_addr!=3 and tx_len!=0, latch addr/len, parity=header, clear tx_err -> FILL. On an illegal tx_start, pulse tx_reject and stay in IDLE. tx_start in any other state is ignored.
  - FILL: tx_data_ready=1. Each valid&&ready handshake writes buf[idx], XORs the byte into parity and increments idx. When the tx_len-th byte is taken, reset idx -> HDR. No bus activity during FILL.
  - HDR: pkt_valid=1, data_in=header. On acceptance -> PAY.
  - PAY: pkt_valid=1, data_in=buf[idx]. On acceptance, idx++. When the last byte (idx==len-1) is accepted -> PAR.
  - PAR: pkt_valid=0, data_in=parity. On acceptance, load wait counter=ERR_WAIT -> CHK.
  - CHK: pkt_valid=0. Any cycle with err=1 sets tx_err. When the counter reaches 0, pulse tx_done -> IDLE.
- pkt_valid falls exactly on the cycle the parity byte is first presented. It never drops mid-payload, because the payload is fully buffered beforehand.
- Length 1 gives HDR, one PAY byte, PAR. Length 63 gives the full buffer with no wrap: idx is 6 bits and never exceeds len-1.
- busy held high indefinitely in any bus state (router FIFO full or wait-till-empty) stalls the transmitter without data loss.
- busy may be high when HDR is entered; the header is held until busy falls.
- tx_done and tx_reject are never high in the same cycle.

Test Plan:
- Basic packet: addr=1, len=3, payload 0x11,0x22,0x33, busy=0 -> bus sequence 0x0D(pv=1), 0x11, 0x22, 0x33 (pv=1), 0x0D(pv=0); tx_done ERW_WAIT+1... specifically tx_done pulses ERR_WAIT cycles after parity acceptance; tx_err=0.
- Back-pressure: same packet with busy=1 for 4 cycles at header and 2 cycles mid-payload -> data_in/pkt_valid held stable during stalls; same byte order; each byte accepted exactly once.
- Illegal requests: tx_start with addr=3, then with len=0 -> tx_reject pulses twice; tx_active stays 0; pkt_valid stays 0.
- Max/min length: len=63 incrementing payload 0x00..0x3E, then len=1 payload 0xA5 -> 64+1 and 2+1 bus bytes; parity = XOR of all bytes including header (len=1, addr=0: header 0x04, parity 0xA1).
- Error capture: pulse err=1 one cycle inside CHK -> tx_err=1 after tx_done; next legal tx_start clears tx_err.
- Async reset mid-PAY (resetn low between edges) -> pkt_valid=0 immediately, state IDLE; a following packet transmits correctly.
